// File: rtl/fifo_stream_reader.sv
// ----------------------------------------------------------------------------
// fifo_stream_reader
//
// Read-side consumer for a FIFO with a one-cycle read latency. Words are
// pulled from the FIFO with rd_en and parked in a three-entry circular skid
// buffer. The head of that buffer is presented to the downstream consumer as
// a valid/ready stream.
//
// rd_en depends only on registered state and on the FIFO/control inputs. It
// never looks at out_ready, so there is no combinational path from the
// downstream ready back into the FIFO. Three entries are enough to sustain one
// word per cycle: one word being presented, one in flight from the FIFO, and
// one spare to absorb a stall.
//
// Parameters
//   DATA_WIDTH     width of the FIFO word and of the stream data
//   COUNT_WIDTH    width of the delivered-word counter
//
// Ports
//   rd_clk         single clock; all logic on the rising edge
//   rd_rst         synchronous, active-high reset
//   drain_en       1 = new FIFO reads allowed, 0 = stop issuing rd_en
//   empty          FIFO empty flag
//   fifo_data_out  FIFO read data, valid one cycle after rd_en
//   rd_en          FIFO read strobe
//   out_data       stream data (head of the skid buffer)
//   out_valid      stream valid
//   out_ready      stream ready from downstream
//   rd_count       number of words delivered, wraps silently
// ----------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   rd_clk,
    input  logic                   rd_rst,
    input  logic                   drain_en,
    input  logic                   empty,
    input  logic [DATA_WIDTH-1:0]  fifo_data_out,
    output logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COUNT_WIDTH-1:0] rd_count
);

    // Skid buffer storage and bookkeeping. Pointers run 0,1,2,0,...
    logic [DATA_WIDTH-1:0] skid_mem [0:2];
    logic [1:0]            head;
    logic [1:0]            tail;
    logic [1:0]            occ;
    logic                  inflight;
    logic                  pop;

    // Advance a buffer pointer modulo three.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A read is only issued when the word it returns is certain to have a
    // slot: the words already stored plus the one already in flight must
    // leave at least one entry free.
    always_comb begin
        rd_en = !rd_rst && drain_en && !empty &&
                (({1'b0, occ} + {2'b00, inflight}) < 3'd3);
    end

    // The stream side is simply the head of the buffer.
    always_comb begin
        out_valid = (occ != 2'd0);
        out_data  = skid_mem[head];
        pop       = out_valid && out_ready;
    end

    // Capture the FIFO word one cycle after its rd_en, retire the head on a
    // handshake. A capture and a pop in the same cycle leave occ unchanged
    // while both pointers move. Reset discards buffered and in-flight words.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            head     <= 2'd0;
            tail     <= 2'd0;
            occ      <= 2'd0;
            inflight <= 1'b0;
            rd_count <= '0;
            for (int i = 0; i < 3; i++) begin
                skid_mem[i] <= '0;
            end
        end else begin
            inflight <= rd_en;
            if (inflight) begin
                skid_mem[tail] <= fifo_data_out;
                tail           <= ptr_inc(tail);
            end
            if (pop) begin
                head     <= ptr_inc(head);
                rd_count <= rd_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            end
            occ <= occ + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ----------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Directed bench for fifo_stream_reader. A small FIFO model with a one-cycle
// read latency feeds the DUT. Inputs change 2 time units after the rising
// edge; outputs are observed after that or on the falling edge. A second
// instance with a 4-bit counter shares all inputs and is used for the
// wrap-around check.
// ----------------------------------------------------------------------------
module tb_fifo_stream_reader;

    logic        rd_clk = 1'b0;
    logic        rd_rst;
    logic        drain_en;
    logic        out_ready;
    logic        empty;
    logic [7:0]  fifo_data_out = 8'h00;
    logic        rd_en;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [15:0] rd_count;

    logic        rd_en_w;
    logic [7:0]  out_data_w;
    logic        out_valid_w;
    logic [3:0]  rd_count_w;

    int checks = 0;
    int errors = 0;

    // FIFO model: words pushed by the stimulus, popped on rd_en.
    logic [7:0] fmem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       fifo_flush = 1'b0;

    // Words delivered on the stream, and a running count of rd_en pulses.
    logic [7:0] rx [0:255];
    int         rx_cnt = 0;
    int         rden_pulses = 0;

    always #5 rd_clk = ~rd_clk;

    fifo_stream_reader #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
        .rd_clk        (rd_clk),
        .rd_rst        (rd_rst),
        .drain_en      (drain_en),
        .empty         (empty),
        .fifo_data_out (fifo_data_out),
        .rd_en         (rd_en),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .rd_count      (rd_count)
    );

    fifo_stream_reader #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut_w (
        .rd_clk        (rd_clk),
        .rd_rst        (rd_rst),
        .drain_en      (drain_en),
        .empty         (empty),
        .fifo_data_out (fifo_data_out),
        .rd_en         (rd_en_w),
        .out_data      (out_data_w),
        .out_valid     (out_valid_w),
        .out_ready     (out_ready),
        .rd_count      (rd_count_w)
    );

    assign empty = (rd_ptr >= wr_ptr);

    // FIFO read port: data appears on fifo_data_out one edge after rd_en.
    // The flush stands in for the system resetting the FIFO read side.
    always @(posedge rd_clk) begin
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (rd_en) begin
            fifo_data_out <= fmem[rd_ptr & 255];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    // Record handshakes and read strobes in the middle of each cycle, where
    // everything the next edge will see is already settled.
    always @(negedge rd_clk) begin
        if (out_valid && out_ready) begin
            rx[rx_cnt & 255] = out_data;
            rx_cnt = rx_cnt + 1;
        end
        if (rd_en) begin
            rden_pulses = rden_pulses + 1;
        end
    end

    task automatic applyStimulus(input logic rst, input logic drain, input logic ready);
        rd_rst    = rst;
        drain_en  = drain;
        out_ready = ready;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #2;
    endtask

    task automatic pushWord(input logic [7:0] w);
        fmem[wr_ptr & 255] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    // Reset both the DUT and the FIFO model for one edge.
    task automatic doReset();
        applyStimulus(1'b1, 1'b1, 1'b1);
        fifo_flush = 1'b1;
        tick();
        fifo_flush = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1);
        #1;
    endtask

    // Directed test sequence, one step after another.
    initial begin
        int p0;
        int r0;
        int vc;
        int first_v;
        int last_v;

        // T1: reset held two cycles with a non-empty FIFO.
        $display("[TB] T1 reset");
        applyStimulus(1'b1, 1'b1, 1'b1);
        pushWord(8'h11);
        #1;
        checkOutput("t1_rden_pre", rd_en, 0);
        tick();
        checkOutput("t1_rden_c1", rd_en, 0);
        checkOutput("t1_valid_c1", out_valid, 0);
        checkOutput("t1_count_c1", rd_count, 0);
        checkOutput("t1_data_c1", out_data, 0);
        tick();
        checkOutput("t1_rden_c2", rd_en, 0);
        checkOutput("t1_valid_c2", out_valid, 0);
        checkOutput("t1_count_c2", rd_count, 0);
        fifo_flush = 1'b1;
        tick();
        fifo_flush = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1);
        #1;

        // T2: single word. rd_en sampled at edge E, data captured at E+1,
        // valid right after E+1, popped at E+2.
        $display("[TB] T2 latency");
        checkOutput("t2_rden_empty", rd_en, 0);
        pushWord(8'hA5);
        #1;
        checkOutput("t2_rden_issue", rd_en, 1);
        checkOutput("t2_valid_issue", out_valid, 0);
        tick();
        checkOutput("t2_rden_after", rd_en, 0);
        checkOutput("t2_valid_inflight", out_valid, 0);
        tick();
        checkOutput("t2_valid", out_valid, 1);
        checkOutput("t2_data", out_data, 8'hA5);
        checkOutput("t2_count_before", rd_count, 0);
        tick();
        checkOutput("t2_count_after", rd_count, 1);
        checkOutput("t2_valid_after", out_valid, 0);
        checkOutput("t2_rden_idle", rd_en, 0);

        // T3: 16 words streamed with out_ready high all the way.
        $display("[TB] T3 streaming");
        doReset();
        r0 = rx_cnt;
        for (int i = 0; i < 16; i++) pushWord(8'(i));
        vc = 0;
        first_v = -1;
        last_v = -1;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (out_valid) begin
                vc++;
                if (first_v < 0) first_v = c;
                last_v = c;
            end
        end
        checkOutput("t3_valid_cycles", vc, 16);
        checkOutput("t3_valid_span", last_v - first_v, 15);
        checkOutput("t3_words", rx_cnt - r0, 16);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("t3_word%0d", i), rx[(r0 + i) & 255], i);
        end
        checkOutput("t3_count", rd_count, 16);

        // T4: backpressure with 10 words queued, then release.
        $display("[TB] T4 backpressure");
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0);
        p0 = rden_pulses;
        for (int i = 0; i < 10; i++) pushWord(8'h40 + 8'(i));
        for (int c = 0; c < 10; c++) tick();
        checkOutput("t4_pulses", rden_pulses - p0, 3);
        checkOutput("t4_rden_held", rd_en, 0);
        checkOutput("t4_valid_held", out_valid, 1);
        checkOutput("t4_data_held", out_data, 8'h40);
        checkOutput("t4_count_held", rd_count, 0);
        r0 = rx_cnt;
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 20; c++) tick();
        checkOutput("t4_words", rx_cnt - r0, 10);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("t4_word%0d", i), rx[(r0 + i) & 255], 8'h40 + i);
        end
        checkOutput("t4_count", rd_count, 10);
        checkOutput("t4_valid_end", out_valid, 0);

        // T5: drain_en dropped right after one rd_en.
        $display("[TB] T5 drain_en");
        doReset();
        r0 = rx_cnt;
        p0 = rden_pulses;
        for (int i = 0; i < 3; i++) pushWord(8'h60 + 8'(i));
        #1;
        checkOutput("t5_rden_first", rd_en, 1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("t5_rden_stopped", rd_en, 0);
        for (int c = 0; c < 6; c++) tick();
        checkOutput("t5_pulses", rden_pulses - p0, 1);
        checkOutput("t5_words_stopped", rx_cnt - r0, 1);
        checkOutput("t5_word0", rx[r0 & 255], 8'h60);
        checkOutput("t5_valid_stopped", out_valid, 0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 10; c++) tick();
        checkOutput("t5_words", rx_cnt - r0, 3);
        checkOutput("t5_word1", rx[(r0 + 1) & 255], 8'h61);
        checkOutput("t5_word2", rx[(r0 + 2) & 255], 8'h62);
        checkOutput("t5_count", rd_count, 3);

        // T6: 17 words wrap the 4-bit counter to 1; reset mid-burst.
        $display("[TB] T6 wrap and reset");
        doReset();
        for (int i = 0; i < 17; i++) pushWord(8'h80 + 8'(i));
        for (int c = 0; c < 30; c++) tick();
        checkOutput("t6_count_w4", rd_count_w, 1);
        checkOutput("t6_count_w16", rd_count, 17);
        for (int i = 0; i < 8; i++) pushWord(8'hC0 + 8'(i));
        for (int c = 0; c < 3; c++) tick();
        checkOutput("t6_valid_burst", out_valid, 1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        fifo_flush = 1'b1;
        #1;
        checkOutput("t6_rden_in_reset", rd_en, 0);
        tick();
        checkOutput("t6_valid_reset", out_valid, 0);
        checkOutput("t6_count_reset", rd_count, 0);
        checkOutput("t6_count_w4_reset", rd_count_w, 0);
        fifo_flush = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1);
        #1;
        checkOutput("t6_rden_flushed", rd_en, 0);
        tick();
        checkOutput("t6_valid_discard", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
